spatz_vrf_arbiter: RTL and testbench
====================================

SPATZ_VRF_ARBITER -- requirements
Module: spatz_vrf_arbiter

Interface
REQ-001 SHALL have parameter NrClients, default 2: number of VRF clients (slide unit, load/store unit, ...), range 2..4.
REQ-002 SHALL have parameter NrWords, default 32: VRF words; power of two.
REQ-003 SHALL have parameter DataWidth, default 64: bits per word; multiple of 8.
REQ-004 SHALL derive AddrWidth = clog2(NrWords) and BeWidth = DataWidth/8.
REQ-005 SHALL have port clk_i, input, 1 bit: the only clock; all state updates on rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: asynchronous reset, active high; one clock, asynchronous active-high reset.
REQ-007 SHALL have port waddr_i, input, NrClients x AddrWidth: per-client write word address.
REQ-008 SHALL have port wdata_i, input, NrClients x DataWidth: per-client write data.
REQ-009 SHALL have port we_i, input, NrClients x 1: per-client write request.
REQ-010 SHALL have port wbe_i, input, NrClients x BeWidth: per-client byte enables.
REQ-011 SHALL have port wvalid_o, output, NrClients x 1: write grant; write commits at the edge ending a cycle with we_i and wvalid_o both high.
REQ-012 SHALL have port raddr_i, input, NrClients x AddrWidth: per-client read word address.
REQ-013 SHALL have port re_i, input, NrClients x 1: per-client read request.
REQ-014 SHALL have port rdata_o, output, NrClients x DataWidth: read data, valid only with rvalid_o.
REQ-015 SHALL have port rvalid_o, output, NrClients x 1: read grant; data returned in the same cycle.

Function
REQ-016 SHALL hold storage as NrWords x DataWidth flops, with one write port and one read port, each arbitrated independently.
REQ-017 Read grant SHALL be combinational: at most one rvalid_o high per cycle; rvalid_o[c] requires re_i[c].
REQ-018 Write grant SHALL be combinational: at most one wvalid_o high per cycle; wvalid_o[c] requires we_i[c].
REQ-019 If any client requests a port, exactly one requester SHALL be granted that cycle (zero-cycle latency, no bubbles).
REQ-020 Each port SHALL arbitrate round-robin: keep a last-granted pointer; grant the first requester strictly after the pointer, wrapping modulo NrClients.
REQ-021 The pointer SHALL update to the granted index at the edge after a grant; with no grant it SHALL hold.
REQ-022 Read and write pointers SHALL be independent; a client may get a read grant and a write grant in the same cycle.
REQ-023 rdata_o[g] SHALL be the stored word at raddr_i[g] for the granted client g; rdata_o of every non-granted client SHALL be all zero.
REQ-024 On a committed write, only bytes with wbe_i set SHALL update; others keep their value; wbe_i all zero commits nothing but still consumes the grant.
REQ-025 Same-cycle read and write to the same address SHALL return the pre-write (old) data; the new data is visible from the next cycle.
REQ-026 Requests SHALL not be queued; a non-granted client keeps requesting, and inputs may change freely between cycles.
REQ-027 Request inputs SHALL be ignored while rst_i is high; no grants are issued during reset.

Reset
REQ-028 rst_i high SHALL asynchronously clear all storage words to zero.
REQ-029 rst_i high SHALL set both pointers to NrClients-1 so that client 0 wins the first contended arbitration.
REQ-030 During reset all wvalid_o, rvalid_o and rdata_o SHALL be 0; reset asserted mid-transfer SHALL discard the write in that cycle.

Verification
REQ-031 Release reset, client 0 reads addr 5 -> rvalid_o[0]=1 same cycle, rdata_o[0]=0.
REQ-032 Client 1 writes addr 3, data 0x1122334455667788, wbe 0x0F, over old 0 -> next-cycle read of addr 3 returns 0x0000000055667788.
REQ-033 Clients 0 and 1 both hold re_i for 4 cycles after reset -> rvalid grants go 0,1,0,1; non-granted rdata_o is 0.
REQ-034 Same cycle: client 0 writes 0xAA..AA to addr 7 (full wbe) while client 1 reads addr 7 -> rdata_o[1]=old value; next cycle read returns 0xAA..AA.
REQ-035 Client 0 holds we_i and re_i together with client 1 idle -> both grants every cycle; pointers stay at 0.
REQ-036 Assert rst_i mid-sequence between two edges with a write pending -> outputs go 0 immediately, storage reads back 0 after release, and client 0 wins the next contention.

Source files
------------

// File: rtl/spatz_vrf_arbiter_if.sv
// Client-side bundle of the VRF arbiter: per-client read/write requests and grants.
// Latency: grants and read data are combinational in the request cycle.
// Backpressure: a client without a grant simply keeps its request up; nothing is queued.
interface spatz_vrf_arbiter_if #(
  parameter int unsigned NrClients = 2,
  parameter int unsigned NrWords   = 32,
  parameter int unsigned DataWidth = 64
);
  localparam int unsigned AddrWidth = $clog2(NrWords);
  localparam int unsigned BeWidth   = DataWidth / 8;

  // Write port
  logic [NrClients-1:0][AddrWidth-1:0] waddr_i;
  logic [NrClients-1:0][DataWidth-1:0] wdata_i;
  logic [NrClients-1:0]                we_i;
  logic [NrClients-1:0][BeWidth-1:0]   wbe_i;
  logic [NrClients-1:0]                wvalid_o;

  // Read port
  logic [NrClients-1:0][AddrWidth-1:0] raddr_i;
  logic [NrClients-1:0]                re_i;
  logic [NrClients-1:0][DataWidth-1:0] rdata_o;
  logic [NrClients-1:0]                rvalid_o;

  // Clients drive requests and observe grants/data
  modport master (
    output waddr_i, wdata_i, we_i, wbe_i, raddr_i, re_i,
    input  wvalid_o, rdata_o, rvalid_o
  );

  // The arbiter observes requests and drives grants/data
  modport slave (
    input  waddr_i, wdata_i, we_i, wbe_i, raddr_i, re_i,
    output wvalid_o, rdata_o, rvalid_o
  );
endinterface

// File: rtl/spatz_vrf_arbiter.sv
// Flop-based vector register file shared by several clients through round-robin read and write ports.
// Latency: zero-cycle grant and read data; a granted write is visible from the next cycle.
// Backpressure: exactly one requester per port wins each cycle; the others hold their request.
module spatz_vrf_arbiter #(
  parameter int unsigned NrClients = 2,
  parameter int unsigned NrWords   = 32,
  parameter int unsigned DataWidth = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  spatz_vrf_arbiter_if.slave vrf
);

  localparam int unsigned AddrWidth = $clog2(NrWords);
  localparam int unsigned BeWidth   = DataWidth / 8;
  localparam int unsigned PtrWidth  = $clog2(NrClients);

  // Round-robin pick: first requester strictly after ptr, wrapping past the last client.
  function automatic logic [NrClients-1:0] rr_pick(
    input logic [NrClients-1:0] req,
    input logic [PtrWidth-1:0]  ptr
  );
    logic [NrClients-1:0] gnt;
    logic                 found;
    int unsigned          idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NrClients; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NrClients) begin
        idx = idx - NrClients;
      end
      if (!found && req[idx[PtrWidth-1:0]]) begin
        gnt[idx[PtrWidth-1:0]] = 1'b1;
        found                  = 1'b1;
      end
    end
    return gnt;
  endfunction

  // One-hot grant to client index (grant is at most one-hot).
  function automatic logic [PtrWidth-1:0] oh_to_idx(input logic [NrClients-1:0] oh);
    logic [PtrWidth-1:0] idx;
    idx = '0;
    for (int unsigned c = 0; c < NrClients; c++) begin
      if (oh[c]) begin
        idx = PtrWidth'(c);
      end
    end
    return idx;
  endfunction

  // Storage and last-granted pointers
  logic [DataWidth-1:0] r_mem [NrWords];
  logic [PtrWidth-1:0]  r_rptr;
  logic [PtrWidth-1:0]  r_wptr;

  // Requests are masked while reset is held so no grant can leak out
  logic [NrClients-1:0] w_rreq;
  logic [NrClients-1:0] w_wreq;
  logic [NrClients-1:0] w_rgnt;
  logic [NrClients-1:0] w_wgnt;
  logic [PtrWidth-1:0]  w_ridx;
  logic [PtrWidth-1:0]  w_widx;
  logic                 w_rany;
  logic                 w_wany;

  assign w_rreq = vrf.re_i & {NrClients{~rst_i}};
  assign w_wreq = vrf.we_i & {NrClients{~rst_i}};
  assign w_rgnt = rr_pick(w_rreq, r_rptr);
  assign w_wgnt = rr_pick(w_wreq, r_wptr);
  assign w_ridx = oh_to_idx(w_rgnt);
  assign w_widx = oh_to_idx(w_wgnt);
  assign w_rany = |w_rgnt;
  assign w_wany = |w_wgnt;

  assign vrf.rvalid_o = w_rgnt;
  assign vrf.wvalid_o = w_wgnt;

  // Selected write beat of the winning client
  logic [AddrWidth-1:0] w_waddr;
  logic [DataWidth-1:0] w_wdata;
  logic [BeWidth-1:0]   w_wbe;

  assign w_waddr = vrf.waddr_i[w_widx];
  assign w_wdata = vrf.wdata_i[w_widx];
  assign w_wbe   = vrf.wbe_i[w_widx];

  // Read data goes only to the granted client; everyone else sees zero
  logic [NrClients-1:0][DataWidth-1:0] w_rdata;

  // Route the addressed word to the read winner (pre-write value on same-address collisions)
  always_comb begin
    w_rdata = '0;
    for (int unsigned c = 0; c < NrClients; c++) begin
      if (w_rgnt[c]) begin
        w_rdata[c] = r_mem[vrf.raddr_i[c]];
      end
    end
  end

  assign vrf.rdata_o = w_rdata;

  // Storage: cleared on reset, byte-masked update on a granted write
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned w = 0; w < NrWords; w++) begin
        r_mem[w] <= '0;
      end
    end else if (w_wany) begin
      for (int unsigned b = 0; b < BeWidth; b++) begin
        if (w_wbe[b]) begin
          r_mem[w_waddr][b*8 +: 8] <= w_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read pointer: park on the last client so client 0 wins first, then track the winner
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rptr <= PtrWidth'(NrClients - 1);
    end else if (w_rany) begin
      r_rptr <= w_ridx;
    end
  end

  // Write pointer: independent of the read side, same rotation rule
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= PtrWidth'(NrClients - 1);
    end else if (w_wany) begin
      r_wptr <= w_widx;
    end
  end

endmodule

// File: tb/tb_spatz_vrf_arbiter.sv
// Bench for spatz_vrf_arbiter: directed scenarios then randomized traffic against a reference model.
// Expected grants/data are queued per cycle and checked by an independent monitor.
module tb_spatz_vrf_arbiter;
  localparam int NC = 3;
  localparam int NW = 32;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int BW = 8;

  logic clk;
  logic rst;

  spatz_vrf_arbiter_if #(.NrClients(NC), .NrWords(NW), .DataWidth(DW)) vrf_if ();

  spatz_vrf_arbiter #(.NrClients(NC), .NrWords(NW), .DataWidth(DW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .vrf   (vrf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NC-1:0]         rv;
    logic [NC-1:0]         wv;
    logic [NC-1:0][DW-1:0] rd;
  } exp_t;

  exp_t exp_q[$];

  // Staged stimulus
  logic                  s_rst;
  logic [NC-1:0]         s_re, s_we;
  logic [NC-1:0][AW-1:0] s_raddr, s_waddr;
  logic [NC-1:0][DW-1:0] s_wdata;
  logic [NC-1:0][BW-1:0] s_wbe;

  // Reference model
  logic [DW-1:0] m_mem [NW];
  int m_rptr, m_wptr;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic int rr(input logic [NC-1:0] req, input int ptr);
    for (int k = 1; k <= NC; k++) begin
      int c;
      c = (ptr + k) % NC;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < NW; w++) m_mem[w] = '0;
    m_rptr = NC - 1;
    m_wptr = NC - 1;
  endtask

  // Expected outcome of the cycle just driven, then advance the model past the coming edge
  task automatic predict();
    exp_t e;
    int g, h;
    e.rv = '0;
    e.wv = '0;
    e.rd = '0;
    if (s_rst) begin
      model_reset();
    end else begin
      g = rr(s_re, m_rptr);
      if (g >= 0) begin
        e.rv[g] = 1'b1;
        e.rd[g] = m_mem[int'(s_raddr[g])];
        m_rptr  = g;
      end
      h = rr(s_we, m_wptr);
      if (h >= 0) begin
        e.wv[h] = 1'b1;
        for (int b = 0; b < BW; b++)
          if (s_wbe[h][b]) m_mem[int'(s_waddr[h])][b*8 +: 8] = s_wdata[h][b*8 +: 8];
        m_wptr = h;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle();
    s_re = '0; s_we = '0; s_raddr = '0; s_waddr = '0; s_wdata = '0; s_wbe = '0;
  endtask

  task automatic step();
    @(negedge clk);
    rst             = s_rst;
    vrf_if.re_i     = s_re;
    vrf_if.we_i     = s_we;
    vrf_if.raddr_i  = s_raddr;
    vrf_if.waddr_i  = s_waddr;
    vrf_if.wdata_i  = s_wdata;
    vrf_if.wbe_i    = s_wbe;
    predict();
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_rvalid", 64'(vrf_if.rvalid_o), 64'(e.rv));
        chk("sb_wvalid", 64'(vrf_if.wvalid_o), 64'(e.wv));
        for (int c = 0; c < NC; c++) chk($sformatf("sb_rdata%0d", c), vrf_if.rdata_o[c], e.rd[c]);
      end
    end
  end

  initial begin
    rst = 1'b1;
    s_rst = 1'b1;
    idle();
    vrf_if.re_i = '0; vrf_if.we_i = '0; vrf_if.raddr_i = '0; vrf_if.waddr_i = '0;
    vrf_if.wdata_i = '0; vrf_if.wbe_i = '0;
    model_reset();

    // Requests during reset must be ignored
    s_re = '1; s_we = '1; s_wbe = '1; s_wdata = '1; s_waddr[0] = 5'd5;
    step();
    #3;
    chk("rst_rvalid", 64'(vrf_if.rvalid_o), 64'd0);
    chk("rst_wvalid", 64'(vrf_if.wvalid_o), 64'd0);
    step();

    // Release reset; client 0 reads addr 5 -> zero, granted same cycle
    s_rst = 1'b0; idle();
    s_re[0] = 1'b1; s_raddr[0] = 5'd5;
    step(); #3;
    chk("r031_rvalid", 64'(vrf_if.rvalid_o), 64'b001);
    chk("r031_rdata", vrf_if.rdata_o[0], 64'd0);

    // Client 1 partial write, then read it back
    idle();
    s_we[1] = 1'b1; s_waddr[1] = 5'd3; s_wdata[1] = 64'h1122334455667788; s_wbe[1] = 8'h0F;
    step(); #3;
    chk("r032_wvalid", 64'(vrf_if.wvalid_o), 64'b010);
    idle();
    s_re[1] = 1'b1; s_raddr[1] = 5'd3;
    step(); #3;
    chk("r032_rdata", vrf_if.rdata_o[1], 64'h0000000055667788);

    // Same-cycle write/read of addr 7: old data now, new data next cycle
    idle();
    s_we[0] = 1'b1; s_waddr[0] = 5'd7; s_wdata[0] = {8{8'hAA}}; s_wbe[0] = 8'hFF;
    s_re[1] = 1'b1; s_raddr[1] = 5'd7;
    step(); #3;
    chk("r034_old", vrf_if.rdata_o[1], 64'd0);
    idle();
    s_re[1] = 1'b1; s_raddr[1] = 5'd7;
    step(); #3;
    chk("r034_new", vrf_if.rdata_o[1], {8{8'hAA}});

    // Client 0 alone on both ports: both grants every cycle
    idle();
    s_re[0] = 1'b1; s_we[0] = 1'b1; s_raddr[0] = 5'd7; s_waddr[0] = 5'd9;
    s_wdata[0] = 64'h0123456789ABCDEF; s_wbe[0] = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      step(); #3;
      chk("r035_rvalid", 64'(vrf_if.rvalid_o), 64'b001);
      chk("r035_wvalid", 64'(vrf_if.wvalid_o), 64'b001);
    end
    // Read pointer parked on 0, so client 1 beats client 0 on contention
    idle();
    s_re[0] = 1'b1; s_re[1] = 1'b1;
    step(); #3;
    chk("r035_ptr", 64'(vrf_if.rvalid_o), 64'b010);

    // Reset asserted between edges with a write pending
    idle();
    s_we[2] = 1'b1; s_waddr[2] = 5'd3; s_wdata[2] = '1; s_wbe[2] = 8'hFF;
    s_re[2] = 1'b1; s_raddr[2] = 5'd7;
    step();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("r036_wvalid", 64'(vrf_if.wvalid_o), 64'd0);
    chk("r036_rvalid", 64'(vrf_if.rvalid_o), 64'd0);
    chk("r036_rdata", vrf_if.rdata_o[2], 64'd0);
    s_rst = 1'b1;
    step();

    // After release: contention 0,1,0,1 with zero data to non-granted clients
    s_rst = 1'b0; idle();
    s_re[0] = 1'b1; s_re[1] = 1'b1; s_raddr[0] = 5'd3; s_raddr[1] = 5'd7;
    for (int i = 0; i < 4; i++) begin
      step(); #3;
      chk("r033_grant", 64'(vrf_if.rvalid_o), (i % 2 == 0) ? 64'b001 : 64'b010);
      chk("r033_idle_rdata", vrf_if.rdata_o[(i % 2 == 0) ? 1 : 0], 64'd0);
      chk("r036_cleared", vrf_if.rdata_o[i % 2], 64'd0);
    end

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      s_rst = ($urandom_range(0, 99) == 0);
      for (int c = 0; c < NC; c++) begin
        s_re[c]    = $urandom_range(0, 2) != 0;
        s_we[c]    = $urandom_range(0, 2) != 0;
        s_raddr[c] = AW'($urandom_range(0, 7));
        s_waddr[c] = AW'($urandom_range(0, 7));
        s_wdata[c] = {$urandom, $urandom};
        s_wbe[c]   = ($urandom_range(0, 7) == 0) ? 8'h00 : BW'($urandom);
      end
      step();
    end

    s_rst = 1'b0; idle();
    step();
    @(negedge clk);
    #3;
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
